// File: rtl/cell_mem_responder.sv
// cell_mem_responder: single responder on the NockPU memory request bus.
// Owns the cell RAM (single-port, synchronous read) and the bump-pointer
// free list. It serves READ, WRITE, ALLOC and NOP requests and signals
// completion through is_ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// INIT      | just out of reset; moves to IDLE on the next edge
// IDLE      | waiting for execute && power; is_ready follows power
// READ      | RAM read issued at the latched address
// READ_DATA | RAM output captured into read_data
// WRITE     | RAM[addr] <= data
// ALLOC     | RAM[free_addr] <= data and bump free_addr, or raise oom
// NOP       | nothing to do; returns to IDLE
module cell_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int FREE_START = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power,
  input  logic                  execute,
  input  logic [1:0]            func,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  is_ready,
  output logic                  oom,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_IDLE      = 4'd1,
    S_READ      = 4'd2,
    S_READ_DATA = 4'd3,
    S_WRITE     = 4'd4,
    S_ALLOC     = 4'd5,
    S_NOP       = 4'd6
  } state_t;

  // The top address is reserved and never handed out by ALLOC.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] FREE_INIT = ADDR_WIDTH'(FREE_START);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic [ADDR_WIDTH-1:0]   free_addr_q, free_addr_d;
  logic                    oom_q, oom_d;

  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0]   ram_rd_q;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    heap_full;

  assign heap_full = (free_addr_q == LAST_ADDR);

  // Control and datapath registers; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      addr_q      <= '0;
      data_q      <= '0;
      read_data_q <= '0;
      free_addr_q <= FREE_INIT;
      oom_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      read_data_q <= read_data_d;
      free_addr_q <= free_addr_d;
      oom_q       <= oom_d;
    end
  end

  // Cell RAM: no reset so preloaded images survive; write enable comes only
  // from registered state, so an aborted WRITE/ALLOC never touches memory.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (state_q == S_READ) begin
      ram_rd_q <= mem[addr_q];
    end
  end

  // Next-state, request latching and RAM write control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    read_data_d = read_data_q;
    free_addr_d = free_addr_q;
    oom_d       = oom_q;
    ram_we      = 1'b0;
    ram_waddr   = addr_q;
    ram_wdata   = data_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (execute && power) begin
          addr_d = address;
          data_d = write_data;
          case (func)
            2'b00:   state_d = S_READ;
            2'b01:   state_d = S_WRITE;
            2'b10:   state_d = S_ALLOC;
            default: state_d = S_NOP;
          endcase
        end
      end
      S_READ: state_d = S_READ_DATA;
      S_READ_DATA: begin
        read_data_d = ram_rd_q;
        state_d     = S_IDLE;
      end
      S_WRITE: begin
        ram_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_ALLOC: begin
        if (!heap_full) begin
          ram_we      = 1'b1;
          ram_waddr   = free_addr_q;
          read_data_d = DATA_WIDTH'(free_addr_q);
          free_addr_d = free_addr_q + ADDR_WIDTH'(1);
        end else begin
          read_data_d = '0;
          oom_d       = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_NOP:   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign is_ready  = (state_q == S_IDLE) && power;
  assign read_data = read_data_q;
  assign free_addr = free_addr_q;
  assign oom       = oom_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cell_mem_responder.sv
// Bench for cell_mem_responder: two instances in lockstep, one with the
// default heap start and one starting next to the top of memory.
module tb_cell_mem_responder;

  localparam logic [1:0] F_READ  = 2'b00;
  localparam logic [1:0] F_WRITE = 2'b01;
  localparam logic [1:0] F_ALLOC = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        power;
  logic        execute;
  logic [1:0]  func;
  logic [9:0]  address;
  logic [63:0] write_data;

  logic [63:0] rd_a, rd_b;
  logic [9:0]  free_a, free_b;
  logic        ready_a, ready_b;
  logic        oom_a, oom_b;
  logic [3:0]  state_a, state_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  always #5 clk = ~clk;

  cell_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .FREE_START(512)) dut_a (
    .clk(clk), .rst(rst), .power(power), .execute(execute), .func(func),
    .address(address), .write_data(write_data), .read_data(rd_a),
    .free_addr(free_a), .is_ready(ready_a), .oom(oom_a), .state(state_a)
  );

  cell_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .FREE_START(1022)) dut_b (
    .clk(clk), .rst(rst), .power(power), .execute(execute), .func(func),
    .address(address), .write_data(write_data), .read_data(rd_b),
    .free_addr(free_b), .is_ready(ready_b), .oom(oom_b), .state(state_b)
  );

  // Called at a negedge with the DUT idle; returns the number of edges after
  // the accept edge until is_ready rises again (99 if it never does).
  task automatic run_op(input logic [1:0] f, input logic [9:0] a,
                        input logic [63:0] d, output int edges);
    int n;
    execute = 1'b1; func = f; address = a; write_data = d;
    @(negedge clk);
    execute = 1'b0; func = 2'b11; address = '0; write_data = '0;
    n = 0;
    while (!ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    edges = ready_a ? n : 99;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (state_a !== 4'd0 || ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: state=%0d ready=%b expected state=0 ready=0", state_a, ready_a);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 0", ready_a);
    end
    @(negedge clk);
    tests_run++;
    if (ready_a !== 1'b1 || state_a !== 4'd1) begin
      tests_failed++;
      $display("FAIL reset_first_ready: ready=%b state=%0d expected ready=1 state=1", ready_a, state_a);
    end
    tests_run++;
    if (free_a !== 10'd512 || oom_a !== 1'b0 || rd_a !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_values: free=%0d oom=%b rd=%h expected 512 0 0", free_a, oom_a, rd_a);
    end
    tests_run++;
    if (free_b !== 10'd1022) begin
      tests_failed++;
      $display("FAIL reset_free_b: got %0d expected 1022", free_b);
    end
  endtask

  task automatic test_write_read();
    int e;
    logic [63:0] exp;
    run_op(F_WRITE, 10'd1, 64'hFEED_FACE_CAFE_BEEF, e);
    do_reset();
    run_op(F_WRITE, 10'd5, 64'h0123_4567_89AB_CDEF, e);
    tests_run++;
    if (e !== 1) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d edges expected 1", e);
    end
    tests_run++;
    if (rd_a !== 64'd0) begin
      tests_failed++;
      $display("FAIL write_keeps_read_data: got %h expected 0", rd_a);
    end
    q_a.push_back(64'h0123_4567_89AB_CDEF);
    run_op(F_READ, 10'd5, 64'd0, e);
    tests_run++;
    if (e !== 2) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d edges expected 2", e);
    end
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL read_addr5: got %h expected %h", rd_a, exp);
    end
    q_a.push_back(64'hFEED_FACE_CAFE_BEEF);
    run_op(F_READ, 10'd1, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL read_preloaded: got %h expected %h", rd_a, exp);
    end
  endtask

  task automatic test_alloc();
    int e;
    logic [63:0] exp;
    do_reset();
    q_a.push_back(64'd512);
    run_op(F_ALLOC, 10'd77, 64'hAAAA_0000_0000_0001, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp || e !== 1) begin
      tests_failed++;
      $display("FAIL alloc_first: rd=%h edges=%0d expected %h edges=1", rd_a, e, exp);
    end
    q_a.push_back(64'd513);
    run_op(F_ALLOC, 10'd3, 64'hBBBB_0000_0000_0002, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL alloc_second: got %h expected %h", rd_a, exp);
    end
    tests_run++;
    if (free_a !== 10'd514) begin
      tests_failed++;
      $display("FAIL alloc_free_addr: got %0d expected 514", free_a);
    end
    q_a.push_back(64'hAAAA_0000_0000_0001);
    run_op(F_READ, 10'd512, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL alloc_read512: got %h expected %h", rd_a, exp);
    end
    q_a.push_back(64'hBBBB_0000_0000_0002);
    run_op(F_READ, 10'd513, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL alloc_read513: got %h expected %h", rd_a, exp);
    end
  endtask

  task automatic test_exhaustion();
    int e;
    logic [63:0] exp;
    do_reset();
    tests_run++;
    if (oom_b !== 1'b0 || free_b !== 10'd1022) begin
      tests_failed++;
      $display("FAIL exhaust_start: oom=%b free=%0d expected 0 1022", oom_b, free_b);
    end
    run_op(F_WRITE, 10'd1023, 64'h5555_6666_7777_8888, e);
    q_b.push_back(64'd1022);
    q_b.push_back(64'd0);
    q_b.push_back(64'd0);
    for (int k = 0; k < 3; k++) begin
      run_op(F_ALLOC, 10'd0, 64'hDEAD_0000_0000_0000 + 64'(k), e);
      exp = q_b.pop_front();
      tests_run++;
      if (rd_b !== exp || free_b !== 10'd1023 || oom_b !== (k != 0)) begin
        tests_failed++;
        $display("FAIL exhaust_alloc%0d: rd=%h free=%0d oom=%b expected rd=%h free=1023 oom=%b",
                 k, rd_b, free_b, oom_b, exp, (k != 0));
      end
    end
    q_b.push_back(64'h5555_6666_7777_8888);
    run_op(F_READ, 10'd1023, 64'd0, e);
    exp = q_b.pop_front();
    tests_run++;
    if (rd_b !== exp) begin
      tests_failed++;
      $display("FAIL exhaust_last_untouched: got %h expected %h", rd_b, exp);
    end
    tests_run++;
    if (oom_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL oom_sticky: got %b expected 1", oom_b);
    end
    do_reset();
    tests_run++;
    if (oom_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL oom_reset_clear: got %b expected 0", oom_b);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [63:0] exp;
    for (int k = 0; k < 6; k++) run_op(F_WRITE, 10'(20 + k), 64'd0, e);
    for (int k = 0; k < 6; k++) begin
      execute = 1'b1; func = F_WRITE; address = 10'(20 + k);
      write_data = 64'hB0 + 64'(k);
      @(negedge clk);
    end
    execute = 1'b0; func = 2'b11;
    for (int k = 0; k < 6; k++) q_a.push_back((k % 2 == 0) ? 64'hB0 + 64'(k) : 64'd0);
    for (int k = 0; k < 6; k++) begin
      run_op(F_READ, 10'(20 + k), 64'd0, e);
      exp = q_a.pop_front();
      tests_run++;
      if (rd_a !== exp) begin
        tests_failed++;
        $display("FAIL b2b_addr%0d: got %h expected %h", 20 + k, rd_a, exp);
      end
    end
  endtask

  task automatic test_busy_pulse();
    int e;
    logic [63:0] exp;
    run_op(F_WRITE, 10'd30, 64'd0, e);
    run_op(F_WRITE, 10'd40, 64'h4040, e);
    execute = 1'b1; func = F_READ; address = 10'd40; write_data = '0;
    @(negedge clk);
    execute = 1'b1; func = F_WRITE; address = 10'd30; write_data = 64'h9999;
    @(negedge clk);
    execute = 1'b0; func = 2'b11;
    @(negedge clk);
    tests_run++;
    if (ready_a !== 1'b1 || rd_a !== 64'h4040) begin
      tests_failed++;
      $display("FAIL busy_read: ready=%b rd=%h expected 1 4040", ready_a, rd_a);
    end
    q_a.push_back(64'd0);
    run_op(F_READ, 10'd30, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL busy_pulse_ignored: got %h expected %h", rd_a, exp);
    end
  endtask

  task automatic test_power();
    int e;
    logic [63:0] exp;
    run_op(F_WRITE, 10'd31, 64'd0, e);
    power = 1'b0;
    #1;
    tests_run++;
    if (ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL power_low_ready: got %b expected 0", ready_a);
    end
    execute = 1'b1; func = F_WRITE; address = 10'd31; write_data = 64'h3131;
    repeat (3) @(negedge clk);
    execute = 1'b0; func = 2'b11;
    tests_run++;
    if (state_a !== 4'd1 || ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL power_low_no_accept: state=%0d ready=%b expected 1 0", state_a, ready_a);
    end
    power = 1'b1;
    q_a.push_back(64'd0);
    run_op(F_READ, 10'd31, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL power_low_write: got %h expected %h", rd_a, exp);
    end
    execute = 1'b1; func = F_READ; address = 10'd5; write_data = '0;
    @(negedge clk);
    execute = 1'b0; power = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (rd_a !== 64'h0123_4567_89AB_CDEF || state_a !== 4'd1 || ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL power_inflight: rd=%h state=%0d ready=%b expected 0123456789abcdef 1 0",
               rd_a, state_a, ready_a);
    end
    power = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int e;
    logic [63:0] exp;
    run_op(F_WRITE, 10'd7, 64'h0700_0000_0000_0007, e);
    run_op(F_ALLOC, 10'd0, 64'h1234, e);
    execute = 1'b1; func = F_WRITE; address = 10'd7; write_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    execute = 1'b0; func = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state_a !== 4'd0 || ready_a !== 1'b0 || rd_a !== 64'd0 ||
        free_a !== 10'd512 || oom_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL midwrite_reset_values: state=%0d ready=%b rd=%h free=%0d oom=%b",
               state_a, ready_a, rd_a, free_a, oom_a);
    end
    rst = 1'b0;
    @(negedge clk);
    q_a.push_back(64'h0700_0000_0000_0007);
    run_op(F_READ, 10'd7, 64'd0, e);
    exp = q_a.pop_front();
    tests_run++;
    if (rd_a !== exp) begin
      tests_failed++;
      $display("FAIL midwrite_ram_kept: got %h expected %h", rd_a, exp);
    end
  endtask

  initial begin
    rst = 1'b1; power = 1'b1; execute = 1'b0; func = 2'b11;
    address = '0; write_data = '0;
    test_reset();
    test_write_read();
    test_alloc();
    test_exhaustion();
    test_back_to_back();
    test_busy_pulse();
    test_power();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
